// File: rtl/sram_sp_banked_ctrl.sv
// sram_sp_banked_ctrl: valid/ready request port in front of a banked array of
// single-port SRAM macros (active-low CEN/GWEN/WEN, 1-cycle read latency).
// Responses are buffered in order in a small FIFO; req_ready is throttled so
// the buffer can never overflow.
// Optional feature macro: SRAM_CTRL_INIT_EN (zero-fills every word after reset).
module sram_sp_banked_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 15,
  parameter int NUM_BANKS = 4,
  parameter int RSP_DEPTH = 3
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W/8-1:0]           req_be,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          init_done,
  output logic [NUM_BANKS-1:0]          sram_cen,
  output logic                          sram_gwen,
  output logic [DATA_W-1:0]             sram_wen,
  output logic [ADDR_W-$clog2(NUM_BANKS)-1:0] sram_a,
  output logic [DATA_W-1:0]             sram_d,
  input  logic [NUM_BANKS*DATA_W-1:0]   sram_q
);

  localparam int BANK_AW = ADDR_W - $clog2(NUM_BANKS);
  localparam int BSEL_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int BE_W    = DATA_W / 8;
  localparam int OCC_W   = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state;
  logic [OCC_W-1:0]    occ;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic                vld_p1;
  logic                write_p1;
  logic [BSEL_W-1:0]   bank_p1;
  logic [BSEL_W-1:0]   req_bank;
  logic                accept, push, pop;
  logic [DATA_W-1:0]   rd_slice, push_data;
  logic [DATA_W:0]     fifo_mem [RSP_DEPTH];
  logic [DATA_W:0]     head;

`ifdef SRAM_CTRL_INIT_EN
  logic [BANK_AW-1:0]  init_cnt;
  logic                init_sweep;
  // The sweep never touches the macros while reset is held.
  assign init_sweep = (state == S_INIT) && !RST;
`endif

  // Active-low per-bit write mask from active-high byte enables.
  function automatic logic [DATA_W-1:0] be_to_wen(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] wen;
    wen = '1;
    for (int i = 0; i < BE_W; i++) wen[8*i +: 8] = {8{~be[i]}};
    return wen;
  endfunction

  // Circular pointer advance for a depth that need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  generate
    if (NUM_BANKS > 1) begin : g_bank_sel
      assign req_bank = req_addr[ADDR_W-1:BANK_AW];
    end else begin : g_one_bank
      assign req_bank = '0;
    end
  endgenerate

  // Inflight access counts against the buffer so the push it produces always fits.
  assign req_ready = (state == S_RUN) && ((32'(occ) + 32'(vld_p1)) < RSP_DEPTH);
  assign accept    = req_valid && req_ready;
  assign push      = vld_p1;
  assign pop       = rsp_valid && rsp_ready;

  assign head      = fifo_mem[rd_ptr];
  assign rsp_valid = (occ != '0);
  assign rsp_write = rsp_valid && head[DATA_W];
  assign rsp_rdata = rsp_valid ? head[DATA_W-1:0] : '0;

  assign rd_slice  = sram_q[32'(bank_p1)*DATA_W +: DATA_W];
  assign push_data = write_p1 ? '0 : rd_slice;

  // Init/run sequencing; init_done is the registered run-state flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_INIT;
      init_done <= 1'b0;
`ifdef SRAM_CTRL_INIT_EN
      init_cnt  <= '0;
`endif
    end else if (state == S_INIT) begin
`ifdef SRAM_CTRL_INIT_EN
      if (init_cnt == '1) begin
        state     <= S_RUN;
        init_done <= 1'b1;
      end else begin
        init_cnt  <= init_cnt + BANK_AW'(1);
      end
`else
      state     <= S_RUN;
      init_done <= 1'b1;
`endif
    end
  end

  // Macro pins: idle unless a request is accepted or the zero-fill sweep runs.
  always_comb begin
    sram_cen  = '1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
`ifdef SRAM_CTRL_INIT_EN
    if (init_sweep) begin
      sram_cen  = '0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_cnt;
    end
`endif
    if (accept) begin
      sram_cen[req_bank] = 1'b0;
      sram_a             = req_addr[BANK_AW-1:0];
      if (req_write) begin
        sram_gwen = 1'b0;
        sram_d    = req_wdata;
        sram_wen  = be_to_wen(req_be);
      end
    end
  end

  // Stage p1: access issued last cycle; control state and FIFO occupancy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p1 <= 1'b0;
      occ    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      vld_p1 <= accept;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Stage p1 data: bank/type of the issued access, then capture into the buffer.
  always_ff @(posedge CLK) begin
    if (accept) begin
      bank_p1  <= req_bank;
      write_p1 <= req_write;
    end
    if (push) fifo_mem[wr_ptr] <= {write_p1, push_data};
  end

endmodule

// File: tb/tb_sram_sp_banked_ctrl.sv
// Directed bench for sram_sp_banked_ctrl with four 8192x32 behavioural macros.
module tb_sram_sp_banked_ctrl;
  localparam int DATA_W = 32, ADDR_W = 15, NUM_BANKS = 4, RSP_DEPTH = 3, BANK_AW = 13;
`ifdef SRAM_CTRL_INIT_EN
  localparam int EXP_INIT = 8192;
`else
  localparam int EXP_INIT = 1;
`endif

  logic                        CLK = 1'b0;
  logic                        RST;
  logic                        req_valid, req_ready, req_write;
  logic [ADDR_W-1:0]           req_addr;
  logic [DATA_W/8-1:0]         req_be;
  logic [DATA_W-1:0]           req_wdata;
  logic                        rsp_valid, rsp_ready, rsp_write;
  logic [DATA_W-1:0]           rsp_rdata;
  logic                        init_done;
  logic [NUM_BANKS-1:0]        sram_cen;
  logic                        sram_gwen;
  logic [DATA_W-1:0]           sram_wen, sram_d;
  logic [BANK_AW-1:0]          sram_a;
  logic [NUM_BANKS*DATA_W-1:0] sram_q;

  logic [31:0] mem [4][8192];
  logic [31:0] bank_q [4];
  logic [32:0] obs_q [$];
  int checks = 0;
  int failures = 0;

  sram_sp_banked_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NUM_BANKS), .RSP_DEPTH(RSP_DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  always #5 CLK = ~CLK;

  // Behavioural macros: masked write, 1-cycle read.
  always @(posedge CLK) begin
    for (int k = 0; k < 4; k++) begin
      if (!sram_cen[k]) begin
        if (!sram_gwen) mem[k][sram_a] <= (mem[k][sram_a] & sram_wen) | (sram_d & ~sram_wen);
        bank_q[k] <= mem[k][sram_a];
      end
    end
  end
  assign sram_q = {bank_q[3], bank_q[2], bank_q[1], bank_q[0]};

  // Response capture.
  always @(posedge CLK) begin
    if (!RST && rsp_valid && rsp_ready) obs_q.push_back({rsp_write, rsp_rdata});
  end

  function automatic logic [14:0] addr_of(input int i);
    return 15'(((i % 4) << 13) | (32'h40 + i));
  endfunction

  function automatic logic [31:0] data_of(input int i);
    return 32'hC0DE0000 | (32'(i) * 32'h1111);
  endfunction

  task automatic idle_req();
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
  endtask

  task automatic wait_rsp(input int n);
    int k;
    k = 0;
    while (obs_q.size() < n && k < 50) begin
      @(posedge CLK);
      k++;
    end
    #1;
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
    end while (!init_done && n < 20000);
    checks++; if (n !== EXP_INIT) begin failures++; $display("FAIL %s_init_cycles: got %0d expected %0d", tag, n, EXP_INIT); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL %s_ready_after_init: got %b expected 1", tag, req_ready); end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; rsp_ready = 1'b0; idle_req();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_write !== 1'b0) begin failures++; $display("FAIL rst_rsp_write: got %b expected 0", rsp_write); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rsp_rdata: got %h expected 0", rsp_rdata); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL rst_init_done: got %b expected 0", init_done); end
    checks++; if (sram_cen !== 4'hF) begin failures++; $display("FAIL rst_cen: got %h expected f", sram_cen); end
    checks++; if (sram_gwen !== 1'b1) begin failures++; $display("FAIL rst_gwen: got %b expected 1", sram_gwen); end
    checks++; if (sram_wen !== 32'hFFFFFFFF) begin failures++; $display("FAIL rst_wen: got %h expected ffffffff", sram_wen); end
    checks++; if (sram_a !== 13'h0) begin failures++; $display("FAIL rst_a: got %h expected 0", sram_a); end
    checks++; if (sram_d !== 32'h0) begin failures++; $display("FAIL rst_d: got %h expected 0", sram_d); end
    @(posedge CLK); #1;
    RST = 1'b0;
    wait_init("reset");
  endtask

  task automatic test_write_read();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h2005; req_be = 4'hF; req_wdata = 32'hDEADBEEF;
    @(negedge CLK);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL wr_ready: got %b expected 1", req_ready); end
    checks++; if (sram_cen !== 4'b1101) begin failures++; $display("FAIL wr_cen: got %b expected 1101", sram_cen); end
    checks++; if (sram_a !== 13'h0005) begin failures++; $display("FAIL wr_a: got %h expected 0005", sram_a); end
    checks++; if (sram_gwen !== 1'b0) begin failures++; $display("FAIL wr_gwen: got %b expected 0", sram_gwen); end
    checks++; if (sram_wen !== 32'h0) begin failures++; $display("FAIL wr_wen: got %h expected 0", sram_wen); end
    checks++; if (sram_d !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_d: got %h expected deadbeef", sram_d); end
    @(posedge CLK); #1;
    req_write = 1'b0; req_wdata = 32'h0;
    @(negedge CLK);
    checks++; if (sram_cen !== 4'b1101) begin failures++; $display("FAIL rd_cen: got %b expected 1101", sram_cen); end
    checks++; if (sram_gwen !== 1'b1) begin failures++; $display("FAIL rd_gwen: got %b expected 1", sram_gwen); end
    checks++; if (sram_wen !== 32'hFFFFFFFF) begin failures++; $display("FAIL rd_wen: got %h expected ffffffff", sram_wen); end
    checks++; if (sram_a !== 13'h0005) begin failures++; $display("FAIL rd_a: got %h expected 0005", sram_a); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_early_valid: got %b expected 0", rsp_valid); end
    @(posedge CLK); #1;
    idle_req();
    @(negedge CLK);
    checks++; if ({rsp_valid, rsp_write, rsp_rdata} !== {2'b11, 32'h0}) begin failures++; $display("FAIL wr_ack: got v=%b w=%b d=%h expected v=1 w=1 d=0", rsp_valid, rsp_write, rsp_rdata); end
    checks++; if (sram_cen !== 4'hF) begin failures++; $display("FAIL idle_cen: got %h expected f", sram_cen); end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if ({rsp_valid, rsp_write, rsp_rdata} !== {2'b10, 32'hDEADBEEF}) begin failures++; $display("FAIL rd_rsp: got v=%b w=%b d=%h expected v=1 w=0 d=deadbeef", rsp_valid, rsp_write, rsp_rdata); end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_drained: got %b expected 0", rsp_valid); end
    @(posedge CLK); #1;
  endtask

  task automatic test_byte_enable();
    obs_q.delete();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h0010; req_be = 4'hF; req_wdata = 32'h11223344;
    @(negedge CLK);
    checks++; if (sram_cen !== 4'b1110) begin failures++; $display("FAIL be_cen: got %b expected 1110", sram_cen); end
    @(posedge CLK); #1;
    req_be = 4'b0101; req_wdata = 32'hAABBCCDD;
    @(negedge CLK);
    checks++; if (sram_wen !== 32'hFF00FF00) begin failures++; $display("FAIL be_wen: got %h expected ff00ff00", sram_wen); end
    @(posedge CLK); #1;
    req_write = 1'b0; req_be = 4'h0; req_wdata = 32'h0;
    @(posedge CLK); #1;
    idle_req();
    wait_rsp(3);
    checks++; if (obs_q.size() !== 3) begin failures++; $display("FAIL be_rsp_count: got %0d expected 3", obs_q.size()); end
    else begin
      checks++; if (obs_q[0] !== {1'b1, 32'h0}) begin failures++; $display("FAIL be_ack0: got %h expected 100000000", obs_q[0]); end
      checks++; if (obs_q[2] !== {1'b0, 32'h11BB33DD}) begin failures++; $display("FAIL be_rdata: got %h expected 011bb33dd", obs_q[2]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] vec;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = addr_of(i); req_be = 4'hF; req_wdata = data_of(i);
      @(negedge CLK);
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_wr_ready%0d: got %b expected 1", i, req_ready); end
      @(posedge CLK); #1;
    end
    idle_req();
    wait_rsp(8);
    repeat (3) @(posedge CLK);
    #1;
    obs_q.delete();
    vec = '0;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr_of(c);
      end else idle_req();
      @(negedge CLK);
      if (c < 8) begin
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_rd_ready%0d: got %b expected 1", c, req_ready); end
      end
      vec[c] = rsp_valid;
      @(posedge CLK); #1;
    end
    checks++; if (vec !== 12'h3FC) begin failures++; $display("FAIL b2b_valid_pattern: got %b expected 001111111100", vec); end
    wait_rsp(8);
    checks++; if (obs_q.size() !== 8) begin failures++; $display("FAIL b2b_count: got %0d expected 8", obs_q.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (obs_q[i] !== {1'b0, data_of(i)}) begin failures++; $display("FAIL b2b_data%0d: got %h expected %h", i, obs_q[i], {1'b0, data_of(i)}); end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    obs_q.delete();
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = addr_of(acc);
      @(negedge CLK);
      if (req_ready) acc++;
      @(posedge CLK); #1;
    end
    checks++; if (acc !== 3) begin failures++; $display("FAIL bp_accepts: got %0d expected 3", acc); end
    @(negedge CLK);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low: got %b expected 0", req_ready); end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_rsp_held: got %b expected 1", rsp_valid); end
    @(posedge CLK); #1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (acc < 5) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr_of(acc);
      end else idle_req();
      @(negedge CLK);
      if (req_valid && req_ready) acc++;
      @(posedge CLK); #1;
    end
    idle_req();
    checks++; if (acc !== 5) begin failures++; $display("FAIL bp_resume: got %0d expected 5", acc); end
    wait_rsp(5);
    checks++; if (obs_q.size() !== 5) begin failures++; $display("FAIL bp_count: got %0d expected 5", obs_q.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (obs_q[i] !== {1'b0, data_of(i)}) begin failures++; $display("FAIL bp_data%0d: got %h expected %h", i, obs_q[i], {1'b0, data_of(i)}); end
      end
    end
  endtask

  task automatic test_reset_midop();
    logic seen;
    obs_q.delete();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = addr_of(i);
      @(negedge CLK);
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_ready%0d: got %b expected 1", i, req_ready); end
      @(posedge CLK); #1;
    end
    idle_req();
    RST = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (sram_cen !== 4'hF) begin failures++; $display("FAIL mid_cen: got %h expected f", sram_cen); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL mid_init_done: got %b expected 0", init_done); end
    @(negedge CLK);
    checks++; if (sram_cen !== 4'hF) begin failures++; $display("FAIL mid_cen_held: got %h expected f", sram_cen); end
    @(posedge CLK); #1;
    RST = 1'b0;
    rsp_ready = 1'b1;
    wait_init("midop");
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (rsp_valid) seen = 1'b1;
    end
    @(posedge CLK); #1;
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_stale_valid: got %b expected 0", seen); end
    checks++; if (obs_q.size() !== 0) begin failures++; $display("FAIL mid_stale_count: got %0d expected 0", obs_q.size()); end
  endtask

`ifdef SRAM_CTRL_INIT_EN
  task automatic test_init_zero();
    obs_q.delete();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h7FFF;
    @(posedge CLK); #1;
    idle_req();
    wait_rsp(1);
    checks++; if (obs_q.size() !== 1) begin failures++; $display("FAIL init_rsp_count: got %0d expected 1", obs_q.size()); end
    else begin
      checks++; if (obs_q[0] !== 33'h0) begin failures++; $display("FAIL init_zero: got %h expected 0", obs_q[0]); end
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
`ifdef SRAM_CTRL_INIT_EN
    test_init_zero();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
